sys_pll_reset_ctrl: RTL

- Controller at the other end of the system PLL's rst/locked interface. It drives the PLL reset and consumes the PLL lock indication.
- Runs on the free-running 50 MHz reference clock, which exists even while the PLL is unlocked.
- Holds the downstream system reset until lock has been stable for a programmable time.
- Re-resets the PLL on lock loss or relock timeout, and counts both event types for debug.

---
 rtl/sys_pll_reset_ctrl.sv | 120 ++++++++++++
 1 files changed

// File: rtl/sys_pll_reset_ctrl.sv
// Sequences the system PLL reset against its lock indication and holds the downstream
// system reset until lock has been stable for a programmable number of refclk cycles.
module sys_pll_reset_ctrl #(
  parameter int unsigned SYNC_STAGES        = 2,
  parameter int unsigned PLL_RST_CYCLES     = 16,
  parameter int unsigned LOCK_STABLE_CYCLES = 1000,
  parameter int unsigned RELOCK_TIMEOUT     = 50000,
  parameter int unsigned CNT_W              = 16
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       pll_locked,
  output logic       pll_rst,
  output logic       sys_rst,
  output logic       ready,
  output logic [1:0] state_o,
  output logic [7:0] lock_loss_cnt,
  output logic [7:0] timeout_cnt
);

  typedef enum logic [1:0] {
    StPllRst   = 2'd0,
    StWaitLock = 2'd1,
    StStable   = 2'd2,
    StRun      = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] RstLast    = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] StableLast = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TmoLast    = CNT_W'(RELOCK_TIMEOUT - 1);

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q;
  logic [CNT_W-1:0]       tmo_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   lock_sync;
  logic                   tmo_hit;
  logic                   timeout_evt;
  logic                   loss_evt;

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pll_locked};
    end
  end

  assign lock_sync = sync_q[SYNC_STAGES-1];
  assign tmo_hit   = (tmo_q == TmoLast);
  assign state_o   = state_q;

  always_comb begin
    state_d     = state_q;
    timeout_evt = 1'b0;
    loss_evt    = 1'b0;
    unique case (state_q)
      StPllRst: begin
        if (cnt_q == RstLast) state_d = StWaitLock;
      end
      StWaitLock: begin
        if (tmo_hit) begin
          state_d     = StPllRst;
          timeout_evt = 1'b1;
        end else if (lock_sync) begin
          state_d = StStable;
        end
      end
      StStable: begin
        // Timeout wins over both a lock drop and qualification completing.
        if (tmo_hit) begin
          state_d     = StPllRst;
          timeout_evt = 1'b1;
        end else if (!lock_sync) begin
          state_d = StWaitLock;
        end else if (cnt_q == StableLast) begin
          state_d = StRun;
        end
      end
      StRun: begin
        if (!lock_sync) begin
          state_d  = StPllRst;
          loss_evt = 1'b1;
        end
      end
      default: state_d = StPllRst;
    endcase
  end

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_q       <= StPllRst;
      cnt_q         <= '0;
      tmo_q         <= '0;
      pll_rst       <= 1'b1;
      sys_rst       <= 1'b1;
      ready         <= 1'b0;
      lock_loss_cnt <= '0;
      timeout_cnt   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= (state_d != state_q) ? '0 : cnt_q + 1'b1;

      // Relock budget spans WAIT_LOCK/STABLE bounces; only a PLL reset restarts it.
      if (state_d == StPllRst) begin
        tmo_q <= '0;
      end else if (state_q == StWaitLock || state_q == StStable) begin
        tmo_q <= tmo_q + 1'b1;
      end

      pll_rst <= (state_d == StPllRst);
      sys_rst <= (state_d != StRun);
      ready   <= (state_d == StRun);

      if (timeout_evt && timeout_cnt != 8'hff) timeout_cnt <= timeout_cnt + 8'd1;
      if (loss_evt && lock_loss_cnt != 8'hff) lock_loss_cnt <= lock_loss_cnt + 8'd1;
    end
  end

endmodule
